// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-serial data memory: start/busy/rol handshake and load extension.
// Optional alignment checking is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_start,
    output logic        mem_wea,
    output logic [2:0]  mem_rol,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;
    logic        accept;
    logic        misaligned;
    logic        wait_done;
    logic        timeout_hit;
    logic [31:0] load_ext;
    logic [2:0]  rol_next;

    assign accept = (state == IDLE) && req;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // cnt==0 marks the first WAIT cycle, where busy may not yet be raised
    assign wait_done   = (state == WAIT) && (cnt != 8'd0) && !mem_busy;
    assign timeout_hit = (state == WAIT) && (cnt != 8'd0) && mem_busy && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !misaligned) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (wait_done)        state_next = DONE;
                else if (timeout_hit) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall     = ((state != IDLE) && (state != DONE)) || accept;
        done      = (state == DONE);
        mem_start = (state == ISSUE);
        mem_wea   = we_q && ((state == ISSUE) || (state == WAIT));
        err       = err_q;
    end

    always_comb begin
        case (size)
            2'b00:   rol_next = 3'd1;
            2'b01:   rol_next = 3'd2;
            default: rol_next = 3'd4;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & mem_rdata[7]}},  mem_rdata[7:0]};
            2'b01:   load_ext = {{16{~uns_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            size_q    <= 2'b10;
            uns_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rol   <= 3'd4;
        end else if (accept && !misaligned) begin
            we_q      <= we;
            size_q    <= size;
            uns_q     <= uns;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_rol   <= rol_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit || (accept && misaligned);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (wait_done && !we_q) begin
            rdata <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed load/store/timeout/reset/alignment vectors.
// Alignment expectations follow `define MEM_ALIGN_CHECK_EN, matching the DUT build.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, err, mem_start, mem_wea;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_rol;
    logic        mem_busy;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // memory model: busy rises the cycle after start and lasts busy_n cycles
    int   busy_n = 0;
    int   busy_left = 0;
    logic hold_busy = 1'b0;

    assign mem_busy = hold_busy || (busy_left > 0);

    always @(posedge clk) begin
        if (mem_start) busy_left <= busy_n;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    mem_access_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .err(err), .mem_start(mem_start), .mem_wea(mem_wea), .mem_rol(mem_rol),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got done=%0b err=%0b expected none", done, err);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_err"},   {31'b0, err},  {31'b0, mon_e.is_err});
                chk({mon_e.name, "_done"},  {31'b0, done}, {31'b0, ~mon_e.is_err});
                chk({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
            end
        end
    end

    task automatic xact(input string name, input logic t_we, input logic [1:0] t_size,
                        input logic t_uns, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [31:0] t_rd, input int t_busy, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [2:0] exp_rol,
                        input logic issue, input int exp_lat);
        exp_t e;
        int starts;
        int lat;
        @(posedge clk);
        #1;
        mem_rdata = t_rd;
        busy_n    = t_busy;
        we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
        req = 1'b1;
        e.is_err = exp_err; e.rdata = exp_rdata; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        chk({name, "_stall_accept"}, {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        starts = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_start) starts++;
            if (k == 1 && issue) begin
                chk({name, "_rol"},   {29'b0, mem_rol}, {29'b0, exp_rol});
                chk({name, "_addr"},  mem_addr, t_addr);
                chk({name, "_wdata"}, mem_wdata, t_wdata);
            end
            if (k <= 2)
                chk({name, "_wea"}, {31'b0, mem_wea}, {31'b0, issue & t_we});
            if (done || err) begin
                lat = k;
                chk({name, "_stall_end"}, {31'b0, stall}, 32'd0);
                break;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_starts"}, starts, issue ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_err",   {31'b0, err},   32'd0);
        chk("rst_start", {31'b0, mem_start}, 32'd0);
        chk("rst_wea",   {31'b0, mem_wea},   32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rol",   {29'b0, mem_rol}, 32'd4);
        @(negedge clk);
        rst = 1'b1;

        xact("lb_s",    1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h000000F3, 3, 1'b0, 32'hFFFFFFF3, 3'd1, 1'b1, 6);
        xact("lh_u",    1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h1234F00D, 1, 1'b0, 32'h0000F00D, 3'd2, 1'b1, 4);
        xact("lh_s",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h1234F00D, 2, 1'b0, 32'hFFFFF00D, 3'd2, 1'b1, 5);
        xact("sw",      1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h55555555, 0, 1'b0, 32'hFFFFF00D, 3'd4, 1'b1, 4);
        xact("lb_u",    1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 0, 1'b0, 32'h00000080, 3'd1, 1'b1, 4);
        xact("lb_pos",  1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'hFFFFFF7F, 0, 1'b0, 32'h0000007F, 3'd1, 1'b1, 4);
        xact("lw_sz11", 1'b0, 2'b11, 1'b0, 32'h18, 32'h0, 32'h89ABCDEF, 1, 1'b0, 32'h89ABCDEF, 3'd4, 1'b1, 4);

        hold_busy = 1'b1;
        xact("timeout", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h01020304, 0, 1'b1, 32'h89ABCDEF, 3'd4, 1'b1, 10);
        hold_busy = 1'b0;
        xact("after_to", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h000000AB, 0, 1'b0, 32'hFFFFFFAB, 3'd1, 1'b1, 4);

        // store interrupted by reset while waiting on busy
        hold_busy = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hA5A5A5A5; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_wea",   {31'b0, mem_wea},   32'd0);
        chk("rstmid_stall", {31'b0, stall},     32'd0);
        chk("rstmid_start", {31'b0, mem_start}, 32'd0);
        chk("rstmid_rdata", rdata, 32'h0);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("rstmid_done", {31'b0, done}, 32'd0);
        chk("rstmid_err",  {31'b0, err},  32'd0);
        rst = 1'b1;

        xact("lh_post", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h00008001, 0, 1'b0, 32'hFFFF8001, 3'd2, 1'b1, 4);
`ifdef MEM_ALIGN_CHECK_EN
        xact("lw_mis",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'hFFFF8001, 3'd4, 1'b0, 1);
`else
        xact("lw_mis",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'hCAFEF00D, 3'd4, 1'b1, 4);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
